image_procesada_writer: RTL and testbench
=========================================

Name: image_procesada_writer

Overview:
- Write-side counterpart to the raw-image byte memory.
- Accepts a stream of processed 8-bit pixels from the processing datapath over a valid/ready handshake.
- Stores the pixels sequentially into an internal frame buffer of DEPTH bytes and signals frame completion.
- Provides an asynchronous read port so the display/dump logic can fetch stored pixels by address.

Parameters:
- DEPTH, 152100, number of pixel bytes per frame (390x390).
- DW, 8, pixel width in bits.
- AW, 18, address width; must satisfy 2^AW >= DEPTH.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin writing a new frame.
- px_valid  in  1  upstream pixel valid.
- px_data  in  DW  upstream pixel value.
- px_ready  out  1  writer can accept a pixel this cycle.
- rd_addr  in  AW  read address.
- rd_data  out  DW  pixel at rd_addr; combinational.
- busy  out  1  frame write in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is written.
- wr_count  out  AW  number of pixels written in the current frame.

Behaviour:
- Clock and reset: single clock domain CLK. RST is asynchronous and active-high.
- Reset values: state=IDLE, px_ready=0, busy=0, frame_done=0, wr_count=0, write address=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - px_ready=0, busy=0.
  - start=1 moves to WRITE next cycle and clears the address and wr_count to 0.
- WRITE:
  - px_ready=1, busy=1.
  - A transfer occurs when px_valid && px_ready at the rising edge. It writes mem[addr]<=px_data and increments addr and wr_count by 1.
  - No transfer: addr and wr_count hold.
  - Transfer at addr==DEPTH-1: writes the last byte and moves to DONE. addr wraps to 0; wr_count holds DEPTH (saturates, no wrap).
  - start while in WRITE or DONE is ignored.
- DONE:
  - frame_done=1 for exactly one cycle, px_ready=0, busy=0.
  - Unconditionally moves to IDLE.
  - A start arriving during DONE is dropped; upstream must re-issue it in IDLE.
- Latency:
  - A pixel accepted at edge N is readable on rd_data from edge N onward (after the write settles).
  - frame_done is high during the cycle following the last transfer edge.
- Read port:
  - rd_data = mem[rd_addr], combinational.
  - rd_addr >= DEPTH returns 0.
  - When reading the address currently being written, rd_data shows the old value until the write edge, then the new value.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial frame is abandoned. Written bytes remain in memory. frame_done is not pulsed.
- Backpressure: px_ready depends only on state, never on px_valid (no combinational loop).

Optional Feature:
- Macro: PIXEL_CHECKSUM_EN.
- With the macro defined:
  - Adds output port checksum [31:0], reset to 0.
  - Cleared to 0 on start accepted in IDLE.
  - On every transfer, checksum <= checksum + zero-extended px_data, with 32-bit wrap.
  - Holds its value through DONE and IDLE until the next start.
- Without the macro: no port and no adder.

Decomposition:
- Package image_pkg:
  - IMG_W=390, IMG_H=390, IMG_BYTES=152100, PIXEL_W=8.
  - typedef pixel_t (logic [7:0]).
  - typedef enum writer_state_t {IDLE, WRITE, DONE}.
- Sub-module frame_buffer_ram: DEPTH x DW array with synchronous write and asynchronous read. Includes the out-of-range-read-returns-0 rule.
- The top level holds the FSM, counters and checksum.

Test Plan:
- Reset behaviour: assert RST mid-WRITE after 5 pixels -> px_ready=0, busy=0, wr_count=0 asynchronously. mem[0..4] retains the written values. No frame_done pulse.
- Full frame (DEPTH=16): start, then 16 back-to-back pixels 0x10..0x1F -> frame_done high exactly one cycle after the 16th edge. wr_count=16. rd_addr=0..15 returns 0x10..0x1F.
- Backpressure/gaps (DEPTH=16): px_valid toggled 1,0,0,1,... -> only valid cycles write. wr_count increments only on transfers. Addresses contain no holes.
- Out-of-range read: rd_addr=16 with DEPTH=16 -> rd_data=0. rd_addr=DEPTH-1 -> last pixel written.
- Start handling: start asserted during WRITE and during the DONE cycle -> ignored, with no counter reset. A subsequent start in IDLE begins a new frame that overwrites from address 0.
- PIXEL_CHECKSUM_EN: DEPTH=4, pixels 0xFF,0x01,0x80,0x7F -> checksum=0x000001FF after frame_done. The next start clears it to 0.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image geometry, pixel type and writer FSM encoding for the processed-image path.
package image_pkg;

  localparam int unsigned IMG_W     = 390;
  localparam int unsigned IMG_H     = 390;
  localparam int unsigned IMG_BYTES = 152100;
  localparam int unsigned PIXEL_W   = 8;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/frame_buffer_ram.sv
// DEPTH x DW frame store: synchronous write, asynchronous read; reads past DEPTH return 0.
module frame_buffer_ram #(
  parameter int unsigned DEPTH = 152100,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  // Contents survive reset on purpose; no reset term here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < AW'(DEPTH)) begin
      rd_data = mem[rd_addr[IW-1:0]];
    end
  end

endmodule

// File: rtl/image_procesada_writer.sv
// Streams processed pixels into a frame buffer and pulses frame_done after the last byte.
// Optional running pixel checksum output when PIXEL_CHECKSUM_EN is defined.
module image_procesada_writer
  import image_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_BYTES,
  parameter int unsigned DW    = PIXEL_W,
  parameter int unsigned AW    = 18
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          px_valid,
  input  logic [DW-1:0] px_data,
  output logic          px_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          frame_done,
`ifdef PIXEL_CHECKSUM_EN
  output logic [AW-1:0] wr_count,
  output logic [31:0]   checksum
`else
  output logic [AW-1:0] wr_count
`endif
);

  writer_state_t state, next_state;
  logic [AW-1:0] addr;
  logic          ready_d, busy_d, done_d;
  logic          xfer, last_xfer;

  assign xfer      = px_valid && px_ready;
  assign last_xfer = xfer && (addr == AW'(DEPTH - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WRITE;
      WRITE:   if (last_xfer) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops aligned with state.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (next_state)
      WRITE:   begin ready_d = 1'b1; busy_d = 1'b1; end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      px_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      px_ready   <= ready_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Address wraps after the last byte while wr_count saturates at DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr     <= '0;
      wr_count <= '0;
    end else if (state == IDLE && start) begin
      addr     <= '0;
      wr_count <= '0;
    end else if (xfer) begin
      if (last_xfer) begin
        addr     <= '0;
        wr_count <= AW'(DEPTH);
      end else begin
        addr     <= addr + AW'(1);
        wr_count <= wr_count + AW'(1);
      end
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + 32'(px_data);
    end
  end
`endif

  frame_buffer_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk     (CLK),
    .we      (xfer),
    .wr_addr (addr),
    .wr_data (px_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_image_procesada_writer.sv
// Randomized self-checking bench for image_procesada_writer with a small frame (DEPTH=16).
module tb_image_procesada_writer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          px_valid;
  logic [DW-1:0] px_data;
  logic          px_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] wr_count;
`ifdef PIXEL_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  image_procesada_writer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_ready   (px_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef PIXEL_CHECKSUM_EN
    .wr_count   (wr_count),
    .checksum   (checksum)
`else
    .wr_count   (wr_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: writing = frame in progress, done_now = cycle right after the last byte.
  bit          m_writing  = 1'b0;
  bit          m_done_now = 1'b0;
  int          m_count    = 0;
  logic [31:0] m_sum      = '0;
  logic [7:0]  m_mem [DEPTH];

  task automatic step(input logic s, input logic v, input logic [7:0] d);
    @(negedge CLK);
    start = s; px_valid = v; px_data = d;
    @(posedge CLK);
    if (m_done_now) begin
      m_done_now = 1'b0;
    end else if (!m_writing) begin
      if (s) begin
        m_writing = 1'b1; m_count = 0; m_sum = '0;
      end
    end else if (v) begin
      m_mem[m_count] = d;
      m_sum = m_sum + {24'd0, d};
      m_count++;
      if (m_count == DEPTH) begin
        m_writing = 1'b0; m_done_now = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 0; px_valid = 0; px_data = '0; rd_addr = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (px_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", px_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", frame_done); end
    n_checks++; if (wr_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", wr_count); end
`ifdef PIXEL_CHECKSUM_EN
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL reset_checksum got=%h want=0", checksum); end
`endif
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_full_frame();
    step(1, 0, 8'h00);
    n_checks++; if (px_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_ready got=%b%b want=11", px_ready, busy); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'(8'h10 + i));
      n_checks++;
      if (wr_count !== AW'(m_count)) begin n_fail++; $display("FAIL full_count got=%0d want=%0d", wr_count, m_count); end
    end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL full_done got=%b want=1", frame_done); end
    n_checks++; if (px_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_done_ready got=%b%b want=00", px_ready, busy); end
    n_checks++; if (wr_count !== AW'(DEPTH)) begin n_fail++; $display("FAIL full_sat got=%0d want=%0d", wr_count, DEPTH); end
`ifdef PIXEL_CHECKSUM_EN
    n_checks++; if (checksum !== m_sum) begin n_fail++; $display("FAIL full_checksum got=%h want=%h", checksum, m_sum); end
`endif
    step(0, 1, 8'hEE);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_width got=%b want=0", frame_done); end
    n_checks++; if (wr_count !== AW'(DEPTH)) begin n_fail++; $display("FAIL idle_hold got=%0d want=%0d", wr_count, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_checks++;
      if (rd_data !== 8'(8'h10 + a)) begin n_fail++; $display("FAIL full_read addr=%0d got=%h want=%h", a, rd_data, 8'(8'h10 + a)); end
    end
    rd_addr = AW'(DEPTH); #1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL oob_read got=%h want=00", rd_data); end
    rd_addr = AW'(31); #1;
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL oob_read_max got=%h want=00", rd_data); end
  endtask

  task automatic test_gaps();
    int cyc = 0;
    step(1, 0, 8'h00);
    while (m_writing && cyc < 400) begin
      step(0, ($urandom_range(0, 2) == 0), 8'($urandom));
      cyc++;
      n_checks++;
      if (wr_count !== AW'(m_count) || frame_done !== m_done_now || px_ready !== m_writing) begin
        n_fail++;
        $display("FAIL gap_cycle got cnt=%0d done=%b rdy=%b want cnt=%0d done=%b rdy=%b",
                 wr_count, frame_done, px_ready, m_count, m_done_now, m_writing);
      end
    end
    n_checks++; if (m_writing) begin n_fail++; $display("FAIL gap_timeout got=writing want=done"); end
`ifdef PIXEL_CHECKSUM_EN
    n_checks++; if (checksum !== m_sum) begin n_fail++; $display("FAIL gap_checksum got=%h want=%h", checksum, m_sum); end
`endif
    step(0, 0, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_checks++;
      if (rd_data !== m_mem[a]) begin n_fail++; $display("FAIL gap_read addr=%0d got=%h want=%h", a, rd_data, m_mem[a]); end
    end
  endtask

  task automatic test_start_ignored();
    step(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom));
    step(1, 1, 8'($urandom));
    n_checks++; if (wr_count !== 5'd6) begin n_fail++; $display("FAIL start_in_write got=%0d want=6", wr_count); end
    while (m_writing) step(0, 1, 8'($urandom));
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL start_done got=%b want=1", frame_done); end
    step(1, 0, 8'h00);
    n_checks++; if (px_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done got=%b%b want=00", px_ready, busy); end
    n_checks++; if (wr_count !== AW'(DEPTH)) begin n_fail++; $display("FAIL start_in_done_cnt got=%0d want=%0d", wr_count, DEPTH); end
`ifdef PIXEL_CHECKSUM_EN
    n_checks++; if (checksum !== m_sum) begin n_fail++; $display("FAIL checksum_hold got=%h want=%h", checksum, m_sum); end
`endif
    step(1, 0, 8'h00);
    n_checks++; if (wr_count !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got cnt=%0d busy=%b want 0/1", wr_count, busy); end
`ifdef PIXEL_CHECKSUM_EN
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL checksum_clear got=%h want=0", checksum); end
`endif
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); #1;
      n_checks++;
      if (rd_data !== m_mem[a]) begin n_fail++; $display("FAIL overwrite_read addr=%0d got=%h want=%h", a, rd_data, m_mem[a]); end
    end
  endtask

  task automatic test_reset_mid();
    // Finishes the frame left open by the previous test, then opens a new one.
    while (m_writing) step(0, 1, 8'($urandom));
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom));
    RST = 1'b1; #1;
    m_writing = 1'b0; m_done_now = 1'b0; m_count = 0; m_sum = '0;
    n_checks++; if (px_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b%b want=00", px_ready, busy); end
    n_checks++; if (wr_count !== '0) begin n_fail++; $display("FAIL rst_mid_count got=%0d want=0", wr_count); end
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00);
      n_checks++; if (frame_done !== 1'b0 || px_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got=%b%b want=00", frame_done, px_ready); end
    end
    for (int a = 0; a < 5; a++) begin
      rd_addr = AW'(a); #1;
      n_checks++;
      if (rd_data !== m_mem[a]) begin n_fail++; $display("FAIL rst_retain addr=%0d got=%h want=%h", a, rd_data, m_mem[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
